// File: rtl/sort_pkg.sv
// Shared defaults and state encoding for the serial sort controller.
package sort_pkg;

  localparam int N_ELEM_DEF   = 9;
  localparam int PASS_LEN_DEF = 10;
  localparam int TAP_DLY_DEF  = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int PERF_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEED   = 3'd2,
    ST_SORT   = 3'd3,
    ST_UNLOAD = 3'd4
  } sort_state_e;

endpackage

// File: rtl/sort_mod_cnt.sv
// Modulo counter: sync clear wins over enable; wraps to 0 after reaching last_i.
module sort_mod_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == last_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sort_sequencer.sv
// Control FSM for the 9-entry serial sort datapath: load, seed, compare passes, unload.
// Optional SORT_PERF_EN adds a saturating busy-cycle counter on perf_cycles_o.
import sort_pkg::*;

module sort_sequencer #(
  parameter int N_ELEM   = N_ELEM_DEF,
  parameter int PASS_LEN = PASS_LEN_DEF,
  parameter int TAP_DLY  = TAP_DLY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              end_i,
  input  logic              is_bigger_i,
  output logic              boot_o,
  output logic              wr_bigger_o,
  output logic              mux_control_o,
  output logic              mux_A_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [PERF_W-1:0] perf_cycles_o
);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] SORT_LAST = CNT_W'(PASS_LEN - 1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] OV_FIRST  = CNT_W'(TAP_DLY);
  localparam logic [CNT_W-1:0] OV_LAST   = CNT_W'(TAP_DLY + N_ELEM - 1);
  localparam logic [CNT_W-1:0] UNLD_LAST = CNT_W'(TAP_DLY + N_ELEM);

  sort_state_e      state_q, state_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cyc_cnt, cyc_last, pass_cnt_unused;
  logic             cyc_tc, pass_tc;

  // Terminal value of the cycle counter depends only on the current phase.
  always_comb begin
    cyc_last = '1;
    case (state_q)
      ST_LOAD:   cyc_last = LOAD_LAST;
      ST_SORT:   cyc_last = SORT_LAST;
      ST_UNLOAD: cyc_last = UNLD_LAST;
      default:   cyc_last = '1;
    endcase
  end

  sort_mod_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_d != state_q),
    .last_i (cyc_last),
    .cnt_o  (cyc_cnt),
    .tc_o   (cyc_tc)
  );

  sort_mod_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   ((state_q == ST_SORT) && cyc_tc),
    .clr_i  (state_q != ST_SORT),
    .last_i (PASS_LAST),
    .cnt_o  (pass_cnt_unused),
    .tc_o   (pass_tc)
  );

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    done_d        = 1'b0;
    in_ready_o    = 1'b0;
    boot_o        = 1'b0;
    wr_bigger_o   = 1'b0;
    mux_control_o = 1'b0;
    mux_A_o       = 1'b0;
    out_valid_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        boot_o     = 1'b1;
        in_ready_o = 1'b1;
        mux_A_o    = 1'b1;
        if (!in_valid_i) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cyc_tc) begin
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        // Extra token makes the chain all-ones for the whole sort phase.
        wr_bigger_o = 1'b1;
        mux_A_o     = 1'b1;
        state_d     = ST_SORT;
      end
      ST_SORT: begin
        mux_control_o = 1'b1;
        wr_bigger_o   = is_bigger_i;
        if (!end_i) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cyc_tc && pass_tc) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        mux_control_o = 1'b1;
        out_valid_o   = (cyc_cnt >= OV_FIRST) && (cyc_cnt <= OV_LAST);
        done_d        = (cyc_cnt == OV_LAST);
        if (cyc_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef SORT_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  // The accept cycle counts as the first one, so the final value is start-to-done inclusive.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE) begin
      if (start_i) perf_d = PERF_W'(1);
    end else if (perf_q != '1) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: scenario table plus randomized runs against a timeline model.
module tb_sort_sequencer;

  localparam int N   = 9;
  localparam int P   = 10;
  localparam int D   = 4;
  // Timeline relative to the accept cycle (t=0): LOAD, SEED, SORT, UNLOAD windows.
  localparam int T_SEED  = N + 1;
  localparam int T_SORT0 = N + 2;
  localparam int T_SORTN = N + 1 + N * P;
  localparam int T_OV0   = T_SORTN + 1 + D;
  localparam int T_DONE  = T_OV0 + N;
  localparam int PERF_FULL = T_DONE + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i, in_valid_i, end_i, is_bigger_i;
  logic in_ready_o, boot_o, wr_bigger_o, mux_control_o, mux_A_o;
  logic out_valid_o, busy_o, done_o, err_o;
  logic [15:0] perf_cycles_o;

  always #5 clk = ~clk;

  sort_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .end_i         (end_i),
    .is_bigger_i   (is_bigger_i),
    .boot_o        (boot_o),
    .wr_bigger_o   (wr_bigger_o),
    .mux_control_o (mux_control_o),
    .mux_A_o       (mux_A_o),
    .out_valid_o   (out_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .perf_cycles_o (perf_cycles_o)
  );

  int total = 0;
  int bad   = 0;
  int n_done, n_ov;

  bit m_busy;
  int m_t;
  bit m_err;
  int m_perf;

  typedef struct {
    bit do_rst;
    bit hold;
    int drop_load;
    int drop_sort;
    int rst_at;
    bit stats;
    int exp_done;
    int exp_ov;
    int exp_err;
    int exp_perf;
  } vec_t;

  function automatic bit rbit();
    return bit'($urandom & 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_load();
    return m_busy && m_t >= 1 && m_t <= N;
  endfunction

  function automatic bit in_sort();
    return m_busy && m_t >= T_SORT0 && m_t <= T_SORTN;
  endfunction

  task automatic check_outputs();
    bit ld, sd, so, ul;
    int exp_perf;
    ld = in_load();
    sd = m_busy && m_t == T_SEED;
    so = in_sort();
    ul = m_busy && m_t > T_SORTN;
`ifdef SORT_PERF_EN
    exp_perf = m_perf;
`else
    exp_perf = 0;
`endif
    chk("in_ready",    int'(in_ready_o),    int'(ld));
    chk("boot",        int'(boot_o),        int'(ld));
    chk("wr_bigger",   int'(wr_bigger_o),   int'(sd || (so && is_bigger_i)));
    chk("mux_control", int'(mux_control_o), int'(so || ul));
    chk("mux_A",       int'(mux_A_o),       int'(ld || sd));
    chk("out_valid",   int'(out_valid_o),   int'(m_busy && m_t >= T_OV0 && m_t < T_OV0 + N));
    chk("busy",        int'(busy_o),        int'(m_busy));
    chk("done",        int'(done_o),        int'(m_busy && m_t == T_DONE));
    chk("err",         int'(err_o),         int'(m_err));
    chk("perf",        int'(perf_cycles_o), exp_perf);
    if (done_o === 1'b1)      n_done++;
    if (out_valid_o === 1'b1) n_ov++;
  endtask

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_err = 0; m_perf = 0;
  endtask

  task automatic model_step();
    bit ld, so;
    ld = in_load();
    so = in_sort();
    if (!m_busy) begin
      if (start_i) begin
        m_busy = 1; m_t = 1; m_err = 0; m_perf = 1;
      end
    end else begin
      if (m_perf < 65535) m_perf++;
      if ((ld && !in_valid_i) || (so && !end_i)) begin
        m_err = 1; m_busy = 0; m_t = 0;
      end else if (m_t == T_DONE) begin
        m_busy = 0; m_t = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances the model at posedge.
  task automatic cycle(input bit s, input bit iv, input bit en, input bit big);
    start_i = s; in_valid_i = iv; end_i = en; is_bigger_i = big;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 0; in_valid_i = 0; end_i = 0; is_bigger_i = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit s, iv, en, fin;
    int gap;
    if (v.do_rst) do_reset();
    n_done = 0;
    n_ov   = 0;
    gap = $urandom_range(0, 3);
    repeat (gap) cycle(1'b0, rbit(), rbit(), rbit());
    fin = 0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (v.rst_at >= 0 && m_busy && m_t == T_SORT0 + v.rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fin = 1;
      end else begin
        s  = (k == 0) || v.hold || (m_busy && ($urandom_range(0, 3) == 0));
        iv = in_load() ? !(m_t - 1 == v.drop_load) : rbit();
        en = in_sort() ? !(m_t - T_SORT0 == v.drop_sort) : rbit();
        cycle(s, iv, en, rbit());
        fin = v.hold ? (k == 119) : !m_busy;
      end
    end
    if (!fin) chk("timeout", 1, 0);
    if (v.stats) begin
      chk("run_done",  n_done, v.exp_done);
      chk("run_ov",    n_ov,   v.exp_ov);
      chk("run_err",   int'(err_o), v.exp_err);
`ifdef SORT_PERF_EN
      chk("run_perf",  int'(perf_cycles_o), v.exp_perf);
`else
      chk("run_perf",  int'(perf_cycles_o), 0);
`endif
    end
  endtask

  initial begin
    vec_t tbl[13];
    vec_t rv;
    //            rst hold dl  ds  ra  st done ov err perf
    tbl[0]  = '{1, 0, -1, -1, -1, 1, 1, N, 0, PERF_FULL};
    tbl[1]  = '{0, 0,  4, -1, -1, 1, 0, 0, 1, 6};
    tbl[2]  = '{0, 0, -1, -1, -1, 1, 1, N, 0, PERF_FULL};
    tbl[3]  = '{0, 0, -1, 20, -1, 1, 0, 0, 1, T_SORT0 + 20 + 1};
    tbl[4]  = '{0, 0, -1, -1, -1, 1, 1, N, 0, PERF_FULL};
    tbl[5]  = '{1, 1, -1, -1, -1, 1, 1, N, 0, 5};
    tbl[6]  = '{1, 0, -1, -1, 43, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, -1, -1, -1, 1, 1, N, 0, PERF_FULL};
    tbl[8]  = '{0, 0,  0, -1, -1, 1, 0, 0, 1, 2};
    tbl[9]  = '{0, 0,  8, -1, -1, 1, 0, 0, 1, 10};
    tbl[10] = '{0, 0, -1,  0, -1, 1, 0, 0, 1, T_SORT0 + 1};
    tbl[11] = '{0, 0, -1, 89, -1, 1, 0, 0, 1, T_SORT0 + 89 + 1};
    tbl[12] = '{0, 0, -1, -1, -1, 1, 1, N, 0, PERF_FULL};
    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      rv = '{0, 0, -1, -1, -1, 0, 0, 0, 0, 0};
      if ($urandom_range(0, 2) == 0)      rv.drop_load = $urandom_range(0, N - 1);
      else if ($urandom_range(0, 1) == 0) rv.drop_sort = $urandom_range(0, N * P - 1);
      run_vec(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
